// File: rtl/jt900h_intctl_pkg.sv
// jt900h_intctl_pkg: shared register indices, FSM states and vector constants
package jt900h_intctl_pkg;
  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_LEVEL = 2'd1;
  localparam logic [1:0] REG_TIMER = 2'd2;
  localparam logic [1:0] REG_CLEAR = 2'd3;
  localparam logic [2:0] VEC_PREFIX = 3'd1;
  localparam logic [2:0] DMA_LVL    = 3'd6;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
endpackage

// File: rtl/jt900h_intctl_timer.sv
// jt900h_intctl_timer: reloadable count-down timer with timer-DMA request pins
module jt900h_intctl_timer
  import jt900h_intctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic [1:0] we,
  input  logic [7:0] rld_in,
  input  logic       dma_in,
  input  logic [1:0] ch_in,
  input  logic [2:0] tl_in,
  input  logic       dma_done,
  output logic       expire,
  output logic [7:0] cnt,
  output logic [7:0] ctl,
  output logic [2:0] lvl,
  output logic       dmaen,
  output logic [1:0] dmach
);
  logic [7:0] rld_q, rld_d, cnt_q, cnt_d;
  logic       run_q, run_d, dma_q, dma_d, dmaen_q, dmaen_d;
  logic [1:0] ch_q, ch_d, dmach_q, dmach_d;
  logic [2:0] tl_q, tl_d;

  always_comb begin
    expire  = cen & run_q & (cnt_q == 8'd1);
    rld_d   = wr & we[1] ? rld_in : rld_q;
    dma_d   = wr & we[0] ? dma_in : dma_q;
    ch_d    = wr & we[0] ? ch_in : ch_q;
    tl_d    = wr & we[0] ? tl_in : tl_q;
    cnt_d   = cen & run_q ? ((expire & dma_q) ? rld_q : cnt_q - 8'd1) : cnt_q;
    run_d   = expire ? dma_q : run_q;
    dmaen_d = (expire & dma_q) | dmaen_q;
    dmach_d = (expire & dma_q) ? ch_q : dmach_q;
    // completion beats a coincident reload; a register write beats everything
    if (cen & dma_done) begin
      run_d   = 1'b0;
      dmaen_d = 1'b0;
    end
    if (wr) begin
      cnt_d = rld_d;
      run_d = rld_d != 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rld_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      dma_q   <= 1'b0;
      ch_q    <= '0;
      tl_q    <= '0;
      dmaen_q <= 1'b0;
      dmach_q <= '0;
    end else begin
      rld_q   <= rld_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      dma_q   <= dma_d;
      ch_q    <= ch_d;
      tl_q    <= tl_d;
      dmaen_q <= dmaen_d;
      dmach_q <= dmach_d;
    end

  assign cnt   = cnt_q;
  assign ctl   = {dma_q, 1'b0, ch_q, 1'b0, tl_q};
  assign lvl   = dma_q ? DMA_LVL : tl_q;
  assign dmaen = dmaen_q;
  assign dmach = dmach_q;
endmodule

// File: rtl/jt900h_intctl.sv
// jt900h_intctl: edge-triggered interrupt collector, priority arbiter and irq handshake
module jt900h_intctl
  import jt900h_intctl_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            cs,
  input  logic [1:0]      addr,
  input  logic [15:0]     din,
  input  logic [1:0]      we,
  output logic [15:0]     dout,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  input  logic            irq_ack,
  output logic [2:0]      int_lvl,
  output logic [7:0]      int_addr,
  output logic            dmaen,
  output logic [1:0]      dmach,
  input  logic            dma_done
);
  localparam int LW = 3 * NSRC;

  state_t          st_q, st_d;
  logic [NSRC:0]   pend_q, pend_d, mask_q, mask_d, req, clr, set;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [NSRC-1:0] src_q, src_d, rise;
  logic [2:0]      il_q, il_d, ix_q, ix_d, win_l, win_i;
  logic [2:0]      lv [NSRC+1];
  logic            win_v, ack_clr, wr_mask, wr_lvl, wr_tmr, wr_clr, t_exp;
  logic [7:0]      t_cnt, t_ctl;
  logic [2:0]      t_lvl;

  assign wr_mask = cs & cen & we[0] & (addr == REG_MASK);
  assign wr_lvl  = cs & cen & (|we) & (addr == REG_LEVEL);
  assign wr_tmr  = cs & cen & (|we) & (addr == REG_TIMER);
  assign wr_clr  = cs & cen & we[0] & (addr == REG_CLEAR);

  jt900h_intctl_timer u_timer (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr_tmr), .we(we),
    .rld_in(din[15:8]), .dma_in(din[7]), .ch_in(din[5:4]), .tl_in(din[2:0]),
    .dma_done(dma_done), .expire(t_exp), .cnt(t_cnt), .ctl(t_ctl),
    .lvl(t_lvl), .dmaen(dmaen), .dmach(dmach)
  );

  // strict compare while scanning upward keeps ties on the lowest index
  always_comb begin
    for (int i = 0; i < NSRC; i++) lv[i] = lvl_q[3*i +: 3];
    lv[NSRC] = t_lvl;
    req   = pend_q & mask_q;
    win_v = 1'b0;
    win_i = '0;
    win_l = '0;
    for (int i = 0; i <= NSRC; i++)
      if (req[i] && lv[i] > win_l) begin
        win_v = 1'b1;
        win_i = 3'(i);
        win_l = lv[i];
      end
  end

  always_comb begin
    st_d    = st_q;
    il_d    = il_q;
    ix_d    = ix_q;
    ack_clr = 1'b0;
    if (cen)
      case (st_q)
        ST_IDLE: if (win_v) begin
          st_d = ST_REQ;
          il_d = win_l;
          ix_d = win_i;
        end
        ST_REQ: if (irq_ack) begin
          st_d    = ST_WAIT;
          ack_clr = 1'b1;
        end
        default: st_d = ST_IDLE;
      endcase
    src_d  = cen ? src : src_q;
    rise   = src & ~src_q;
    set    = cen ? {t_exp, rise} : '0;
    clr    = (wr_clr ? din[NSRC:0] : '0) | (ack_clr ? {{NSRC{1'b0}}, 1'b1} << ix_q : '0);
    pend_d = (pend_q & ~clr) | set;
    mask_d = wr_mask ? din[NSRC:0] : mask_q;
    for (int b = 0; b < LW; b++) lvl_d[b] = wr_lvl && we[b/8] ? din[b] : lvl_q[b];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q   <= ST_IDLE;
      il_q   <= '0;
      ix_q   <= '0;
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      lvl_q  <= '0;
    end else begin
      st_q   <= st_d;
      il_q   <= il_d;
      ix_q   <= ix_d;
      src_q  <= src_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      lvl_q  <= lvl_d;
    end

  assign irq      = st_q == ST_REQ;
  assign int_lvl  = il_q;
  assign int_addr = {VEC_PREFIX, ix_q, 2'b00};

  always_comb
    dout = addr == REG_MASK  ? {2'b00, 6'(pend_q), 2'b00, 6'(mask_q)} :
           addr == REG_LEVEL ? 16'(lvl_q) :
           addr == REG_TIMER ? {t_cnt, t_ctl} : 16'h0000;
endmodule

// File: tb/tb_jt900h_intctl.sv
// tb_jt900h_intctl: directed plan plus randomized traffic checked against a behavioural model
module tb_jt900h_intctl;
  logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, cs = 1'b0, irq_ack = 1'b0, dma_done = 1'b0;
  logic [1:0]  addr = '0, we = '0;
  logic [15:0] din = '0;
  logic [3:0]  src = '0;
  logic [15:0] dout;
  logic        irq, dmaen;
  logic [2:0]  int_lvl;
  logic [7:0]  int_addr;
  logic [1:0]  dmach;
  int total = 0, bad = 0;

  jt900h_intctl #(.NSRC(4)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs(cs), .addr(addr), .din(din), .we(we),
    .dout(dout), .src(src), .irq(irq), .irq_ack(irq_ack), .int_lvl(int_lvl),
    .int_addr(int_addr), .dmaen(dmaen), .dmach(dmach), .dma_done(dma_done)
  );

  always #10 clk = ~clk;

  // behavioural model: pending/mask bit vectors, a 3-phase handshake and a plain down-counter
  logic [4:0]  m_pend, m_mask;
  logic [11:0] m_lvl;
  logic [7:0]  m_rld, m_cnt;
  logic        m_run, m_dma, m_dmaen;
  logic [1:0]  m_ch, m_dmach;
  logic [2:0]  m_tl;
  logic [3:0]  m_prev;
  int          m_phase, m_ix, m_il;

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_lvl = 0; m_rld = 0; m_cnt = 0; m_run = 0; m_dma = 0;
    m_dmaen = 0; m_ch = 0; m_dmach = 0; m_tl = 0; m_prev = 0; m_phase = 0; m_ix = 0; m_il = 0;
  endtask

  function automatic int lev(int i);
    return i == 4 ? (m_dma ? 6 : int'(m_tl)) : int'((m_lvl >> (3 * i)) & 12'h7);
  endfunction

  function automatic logic [15:0] m_rd(logic [1:0] a);
    case (a)
      2'd0: return {3'b0, m_pend, 3'b0, m_mask};
      2'd1: return {4'b0, m_lvl};
      2'd2: return {m_cnt, m_dma, 1'b0, m_ch, 1'b0, m_tl};
      default: return 16'h0;
    endcase
  endfunction

  task automatic m_step();
    logic [4:0] set, clr;
    int best, bl;
    bit wr;
    set = {1'b0, src & ~m_prev};
    m_prev = src;
    clr = 0;
    best = -1;
    bl = 0;
    for (int i = 4; i >= 0; i--)
      if (m_pend[i] && m_mask[i] && lev(i) > 0 && lev(i) >= bl) begin best = i; bl = lev(i); end
    case (m_phase)
      0: if (best >= 0) begin m_phase = 1; m_ix = best; m_il = bl; end
      1: if (irq_ack) begin m_phase = 2; clr[m_ix] = 1'b1; end
      default: m_phase = 0;
    endcase
    if (m_run) begin
      if (m_cnt == 1) begin
        set[4] = 1'b1;
        if (m_dma) begin m_cnt = m_rld; m_dmaen = 1; m_dmach = m_ch; end
        else begin m_cnt = 0; m_run = 0; end
      end else m_cnt = m_cnt - 1;
    end
    if (dma_done) begin m_dmaen = 0; m_run = 0; end
    wr = cs && we != 0;
    if (wr && addr == 2) begin
      if (we[1]) m_rld = din[15:8];
      if (we[0]) begin m_dma = din[7]; m_ch = din[5:4]; m_tl = din[2:0]; end
      m_cnt = m_rld;
      m_run = m_rld != 0;
    end
    if (wr && addr == 0 && we[0]) m_mask = din[4:0];
    if (wr && addr == 1) begin
      if (we[0]) m_lvl[7:0] = din[7:0];
      if (we[1]) m_lvl[11:8] = din[11:8];
    end
    if (wr && addr == 3 && we[0]) clr = clr | din[4:0];
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp();
    chk("irq", 16'(irq), 16'(m_phase == 1));
    chk("int_lvl", 16'(int_lvl), 16'(m_il));
    chk("int_addr", 16'(int_addr), 16'(32 + 4 * m_ix));
    chk("dmaen", 16'(dmaen), 16'(m_dmaen));
    chk("dmach", 16'(dmach), 16'(m_dmach));
    chk("dout", dout, m_rd(addr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && cen) m_step();
    @(negedge clk);
    cmp();
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    cs = 1; addr = a; din = d; we = 2'b11;
    tick();
    cs = 0; we = 0;
  endtask

  task automatic rd(logic [1:0] a, logic [15:0] exp, string tag);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic ack();
    irq_ack = 1;
    tick();
    irq_ack = 0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_lvl", 16'(int_lvl), 16'h0);
    chk("rst_addr", 16'(int_addr), 16'h20);
    chk("rst_dma", 16'({dmaen, dmach}), 16'h0);
    rd(0, 16'h0, "rst_mask"); rd(1, 16'h0, "rst_level"); rd(2, 16'h0, "rst_timer");
    rst = 0;
    idle(2);

    // single source
    wr(0, 16'h0001); wr(1, 16'h0003); addr = 0;
    src = 4'b0001; tick(); src = 0;
    rd(0, 16'h0101, "t1_pend");
    chk("t1_irq_early", 16'(irq), 16'h0);
    tick();
    chk("t1_irq", 16'(irq), 16'h1); chk("t1_lvl", 16'(int_lvl), 16'h3); chk("t1_addr", 16'(int_addr), 16'h20);
    ack();
    chk("t1_irq_ack", 16'(irq), 16'h0); rd(0, 16'h0001, "t1_pend_clr");
    idle(2);

    // level priority
    wr(0, 16'h0003); wr(1, 16'h002A);
    src = 4'b0011; tick(); src = 0; tick();
    chk("t2_lvl_a", 16'(int_lvl), 16'h5); chk("t2_addr_a", 16'(int_addr), 16'h24);
    ack(); idle(2);
    chk("t2_irq_b", 16'(irq), 16'h1); chk("t2_lvl_b", 16'(int_lvl), 16'h2); chk("t2_addr_b", 16'(int_addr), 16'h20);
    ack(); idle(2);

    // equal levels
    wr(0, 16'h000C); wr(1, 16'h0900);
    src = 4'b1100; tick(); src = 0; tick();
    chk("t3_addr_a", 16'(int_addr), 16'h28); chk("t3_lvl", 16'(int_lvl), 16'h4);
    ack(); idle(2);
    chk("t3_addr_b", 16'(int_addr), 16'h2C);
    ack(); idle(2);

    // one-shot timer
    wr(0, 16'h0010); wr(2, 16'h0503);
    rd(2, 16'h0503, "t4_load");
    idle(4); rd(0, 16'h0010, "t4_not_yet");
    tick(); rd(0, 16'h1010, "t4_expire");
    tick();
    chk("t4_irq", 16'(irq), 16'h1); chk("t4_lvl", 16'(int_lvl), 16'h3); chk("t4_addr", 16'(int_addr), 16'h30);
    rd(2, 16'h0003, "t4_stopped");
    ack(); idle(6); rd(0, 16'h0010, "t4_no_more");

    // timer-DMA mode
    wr(2, 16'h0490); addr = 0;
    idle(4);
    chk("t5_dmaen", 16'(dmaen), 16'h1); chk("t5_dmach", 16'(dmach), 16'h1); rd(0, 16'h1010, "t5_pend");
    tick();
    chk("t5_irq", 16'(irq), 16'h1); chk("t5_lvl", 16'(int_lvl), 16'h6);
    ack(); idle(2);
    rd(0, 16'h1010, "t5_periodic");
    dma_done = 1; tick(); dma_done = 0;
    chk("t5_done", 16'(dmaen), 16'h0);
    ack(); idle(8);
    rd(0, 16'h0010, "t5_halt");

    // dma_done coincident with a reload
    wr(0, 16'h0000); wr(2, 16'h0290);
    tick(); dma_done = 1; tick(); dma_done = 0;
    chk("t6_dmaen", 16'(dmaen), 16'h0); rd(0, 16'h1000, "t6_pend");
    idle(4); rd(2, 16'h0290, "t6_frozen");
    wr(3, 16'h001F);

    // clear write racing a rising edge
    src = 4'b0010; wr(3, 16'h0002); src = 0;
    rd(0, 16'h0200, "t7_set_wins");
    wr(3, 16'h001F); rd(0, 16'h0000, "t7_cleared");

    // clock enable low freezes sampling and writes
    wr(0, 16'h0001); wr(1, 16'h0001);
    cen = 0; src = 4'b0001; idle(3);
    wr(0, 16'h001F); src = 0; idle(1); cen = 1; idle(3);
    rd(0, 16'h0001, "t8_frozen"); chk("t8_irq", 16'(irq), 16'h0);

    // asynchronous reset while a request is presented
    wr(1, 16'h0007); src = 4'b0001; tick(); src = 0; tick();
    chk("t9_irq", 16'(irq), 16'h1);
    rst = 1; #1;
    chk("t9_irq_async", 16'(irq), 16'h0);
    m_reset();
    rd(0, 16'h0, "t9_mask"); rd(1, 16'h0, "t9_level"); rd(2, 16'h0, "t9_timer");
    chk("t9_addr", 16'(int_addr), 16'h20);
    tick(); rst = 0; idle(2);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      cen = $urandom_range(0, 3) != 0;
      src = 4'($urandom_range(0, 15));
      irq_ack = m_phase == 1 && $urandom_range(0, 2) == 0;
      dma_done = $urandom_range(0, 15) == 0;
      addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        cs = 1;
        we = 2'($urandom_range(1, 3));
        din = addr == 2 ? {8'($urandom_range(0, 6)), 8'($urandom)} : 16'($urandom);
      end else begin
        cs = 0; we = 0;
      end
      tick();
    end
    cs = 0; we = 0; irq_ack = 0; dma_done = 0; cen = 1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
